// File: rtl/ch4_code_serializer.sv
// Bit-serial transmitter for the CH4 gas-alarm link: sends CODE MSB first,
// optionally repeated with idle-low gaps, under a start/busy/done/abort handshake.
module ch4_code_serializer #(
  parameter int                  CODE_LEN = 10,
  parameter logic [CODE_LEN-1:0] CODE     = 10'b1011101010,
  parameter int                  GAP      = 1,
  parameter int                  REPEAT_W = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [REPEAT_W-1:0] repeat_n,
  input  logic                abort,
  output logic                x_out,
  output logic                busy,
  output logic                frame_end,
  output logic                done
);

  localparam int BIT_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CODE_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [REPEAT_W-1:0] frames_q, frames_d;
  logic                x_q, x_d;
  logic                busy_q, busy_d;
  logic                fe_q, fe_d;
  logic                done_q, done_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      gap_q    <= '0;
      frames_q <= '0;
      x_q      <= 1'b0;
      busy_q   <= 1'b0;
      fe_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      frames_q <= frames_d;
      x_q      <= x_d;
      busy_q   <= busy_d;
      fe_q     <= fe_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    frames_d = frames_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_SEND;
          bit_d    = BIT_LAST;
          frames_d = repeat_n;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_q != '0) begin
          bit_d = bit_q - BIT_W'(1);
        end else if (GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LAST;
        end else if (frames_q != '0) begin
          frames_d = frames_q - REPEAT_W'(1);
          bit_d    = BIT_LAST;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (frames_q != '0) begin
          frames_d = frames_q - REPEAT_W'(1);
          bit_d    = BIT_LAST;
          state_d  = S_SEND;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they land in flops.
    x_d    = (state_d == S_SEND) ? CODE[bit_d] : 1'b0;
    busy_d = (state_d != S_IDLE);
    fe_d   = (state_d == S_SEND) && (bit_d == '0);
  end

  assign x_out     = x_q;
  assign busy      = busy_q;
  assign frame_end = fe_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ch4_code_serializer.sv
// Bench for ch4_code_serializer: a GAP=1 and a GAP=0 instance checked cycle by
// cycle against a frame-timeline model, plus a simple CH4 receiver on the GAP=0 line.
module tb_ch4_code_serializer;

  localparam int               CODE_LEN = 10;
  localparam logic [9:0]       CODE_W   = 10'b1011101010;

  logic       CLK;
  logic       RST;
  logic       start_a, abort_a, start_b, abort_b;
  logic [2:0] rep_a, rep_b;
  logic       x_a, busy_a, fe_a, done_a;
  logic       x_b, busy_b, fe_b, done_b;

  int checks = 0;
  int errors = 0;

  ch4_code_serializer #(.CODE_LEN(CODE_LEN), .CODE(CODE_W), .GAP(1), .REPEAT_W(3)) u_dut_a (
    .CLK(CLK), .RST(RST), .start(start_a), .repeat_n(rep_a), .abort(abort_a),
    .x_out(x_a), .busy(busy_a), .frame_end(fe_a), .done(done_a)
  );

  ch4_code_serializer #(.CODE_LEN(CODE_LEN), .CODE(CODE_W), .GAP(0), .REPEAT_W(3)) u_dut_b (
    .CLK(CLK), .RST(RST), .start(start_b), .repeat_n(rep_b), .abort(abort_b),
    .x_out(x_b), .busy(busy_b), .frame_end(fe_b), .done(done_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Receiver on the back-to-back line: match is high the cycle after the last bit arrives.
  logic [9:0] sr_b;
  logic       z_b;
  always @(posedge CLK or negedge RST) begin
    if (!RST) sr_b <= '0;
    else      sr_b <= {sr_b[8:0], x_b};
  end
  assign z_b = (sr_b == CODE_W);

  // Expected {x_out, busy, frame_end, done} at cycle cyc after the accepting edge.
  function automatic logic [3:0] model(int rep, int gap, int cyc);
    int flen;
    int total;
    int k;
    logic [9:0] code;
    code  = CODE_W;
    flen  = CODE_LEN + gap;
    total = (rep + 1) * flen;
    if (cyc < 1) return 4'b0000;
    if (cyc > total) return (cyc == total + 1) ? 4'b0001 : 4'b0000;
    k = (cyc - 1) % flen;
    if (k >= CODE_LEN) return 4'b0100;
    return {code[CODE_LEN-1-k], 1'b1, (k == CODE_LEN - 1), 1'b0};
  endfunction

  task automatic kick_a(int rep);
    @(negedge CLK);
    start_a = 1'b1;
    rep_a   = 3'(rep);
    @(posedge CLK);
    #1;
    start_a = 1'b0;
    rep_a   = 3'($urandom);
  endtask

  task automatic kick_b(int rep);
    @(negedge CLK);
    start_b = 1'b1;
    rep_b   = 3'(rep);
    @(posedge CLK);
    #1;
    start_b = 1'b0;
    rep_b   = 3'($urandom);
  endtask

  task automatic test_reset();
    logic [3:0] got;
    RST = 1'b0;
    #2;
    got = {x_a, busy_a, fe_a, done_a};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_a got=%b exp=0000", got);
    end
    got = {x_b, busy_b, fe_b, done_b};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_b got=%b exp=0000", got);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    got = {x_a, busy_a, fe_a, done_a};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset got=%b exp=0000", got);
    end
  endtask

  task automatic test_single_frame();
    logic [3:0] got, exp;
    kick_a(0);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge CLK);
      got = {x_a, busy_a, fe_a, done_a};
      exp = model(0, 1, cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_frame cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
  endtask

  // Random repeat counts; start and repeat_n wiggle while busy and must be ignored.
  task automatic test_repeat_ignored_start();
    logic [3:0] got, exp;
    int rep, total;
    for (int it = 0; it < 4; it++) begin
      rep   = (it == 0) ? 2 : int'($urandom_range(0, 7));
      total = (rep + 1) * (CODE_LEN + 1);
      kick_a(rep);
      for (int cyc = 1; cyc <= total + 3; cyc++) begin
        @(negedge CLK);
        got = {x_a, busy_a, fe_a, done_a};
        exp = model(rep, 1, cyc);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL repeat rep=%0d cyc=%0d got=%b exp=%b", rep, cyc, got, exp);
        end
        start_a = (cyc <= total) ? 1'($urandom) : 1'b0;
        rep_a   = 3'($urandom);
      end
      start_a = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp, prev;
    int rep, total, hits;
    for (int it = 0; it < 3; it++) begin
      rep   = (it == 0) ? 1 : int'($urandom_range(0, 7));
      total = (rep + 1) * CODE_LEN;
      hits  = 0;
      kick_b(rep);
      for (int cyc = 1; cyc <= total + 3; cyc++) begin
        @(negedge CLK);
        got  = {x_b, busy_b, fe_b, done_b};
        exp  = model(rep, 0, cyc);
        prev = model(rep, 0, cyc - 1);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL b2b rep=%0d cyc=%0d got=%b exp=%b", rep, cyc, got, exp);
        end
        checks++;
        if (z_b !== prev[1]) begin
          errors++;
          $display("FAIL b2b_detect rep=%0d cyc=%0d got=%b exp=%b", rep, cyc, z_b, prev[1]);
        end
        if (z_b === 1'b1) hits++;
      end
      checks++;
      if (hits != rep + 1) begin
        errors++;
        $display("FAIL b2b_detect_count rep=%0d got=%0d exp=%0d", rep, hits, rep + 1);
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0] got, exp;
    int rep, at, total;
    for (int it = 0; it < 4; it++) begin
      rep   = (it == 0) ? 0 : int'($urandom_range(0, 3));
      total = (rep + 1) * (CODE_LEN + 1);
      at    = (it == 0) ? 5 : int'($urandom_range(1, total));
      kick_a(rep);
      for (int cyc = 1; cyc <= total + 3; cyc++) begin
        @(negedge CLK);
        got = {x_a, busy_a, fe_a, done_a};
        exp = (cyc <= at) ? model(rep, 1, cyc) : 4'b0000;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL abort rep=%0d at=%0d cyc=%0d got=%b exp=%b", rep, at, cyc, got, exp);
        end
        start_a = (it == 0 && cyc == 3) ? 1'b1 : 1'b0;
        abort_a = (cyc == at) ? 1'b1 : 1'b0;
      end
      start_a = 1'b0;
      abort_a = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] got, exp;
    kick_a(0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge CLK);
      got = {x_a, busy_a, fe_a, done_a};
      exp = model(0, 1, cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
    #1 RST = 1'b0;
    #1;
    got = {x_a, busy_a, fe_a, done_a};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got=%b exp=0000", got);
    end
    #1 RST = 1'b1;
    kick_a(0);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge CLK);
      got = {x_a, busy_a, fe_a, done_a};
      exp = model(0, 1, cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_start_abort_idle();
    logic [3:0] got, exp;
    @(negedge CLK);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(posedge CLK);
    #1;
    start_a = 1'b0;
    abort_a = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge CLK);
      got = {x_a, busy_a, fe_a, done_a};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL start_abort_idle cyc=%0d got=%b exp=0000", cyc, got);
      end
    end
    kick_a(0);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge CLK);
      got = {x_a, busy_a, fe_a, done_a};
      exp = model(0, 1, cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL start_after_abort cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
  endtask

  // A start presented in the done cycle is accepted immediately.
  task automatic test_done_restart();
    logic [3:0] got, exp;
    int rep2, total2;
    rep2   = int'($urandom_range(0, 3));
    total2 = (rep2 + 1) * (CODE_LEN + 1);
    kick_a(0);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge CLK);
      got = {x_a, busy_a, fe_a, done_a};
      exp = model(0, 1, cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL restart_first cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
    start_a = 1'b1;
    rep_a   = 3'(rep2);
    @(posedge CLK);
    #1;
    start_a = 1'b0;
    rep_a   = 3'($urandom);
    for (int cyc = 1; cyc <= total2 + 2; cyc++) begin
      @(negedge CLK);
      got = {x_a, busy_a, fe_a, done_a};
      exp = model(rep2, 1, cyc);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL restart_second rep=%0d cyc=%0d got=%b exp=%b", rep2, cyc, got, exp);
      end
    end
  endtask

  initial begin
    start_a = 1'b0; abort_a = 1'b0; rep_a = '0;
    start_b = 1'b0; abort_b = 1'b0; rep_b = '0;
    RST = 1'b1;
    test_reset();
    test_single_frame();
    test_repeat_ignored_start();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_start_abort_idle();
    test_done_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
